// File: rtl/boot_pkg.sv
// Shared types and constants for the boot image loader: FSM states, widths,
// the SRAM macro request bundle and its idle value.
package boot_pkg;

  typedef enum logic [2:0] {IDLE, FILL, WRITE, RELEASE, DONE} state_e;

  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 14;
  localparam int IDX_W     = 15;
  localparam int NUM_LANES = WORD_W / 8;
  localparam int LANE_W    = $clog2(NUM_LANES);

  localparam logic              CEB_IDLE  = 1'b1;
  localparam logic              WEB_IDLE  = 1'b1;
  localparam logic [WORD_W-1:0] BWEB_IDLE = '1;

  typedef struct packed {
    logic              ceb;
    logic              web;
    logic [WORD_W-1:0] bweb;
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] di;
  } sram_req_t;

  localparam sram_req_t SRAM_IDLE = '{ceb: CEB_IDLE, web: WEB_IDLE, bweb: BWEB_IDLE,
                                      a: '0, di: '0};

  // Received lanes are written (bweb low), the rest are masked off.
  function automatic logic [WORD_W-1:0] lanes_to_bweb(input logic [NUM_LANES-1:0] mask);
    logic [WORD_W-1:0] bweb;
    for (int i = 0; i < NUM_LANES; i++) bweb[i*8 +: 8] = {8{~mask[i]}};
    return bweb;
  endfunction

endpackage

// File: rtl/boot_byte_packer.sv
// Assembles little-endian bytes into one word; tracks which lanes arrived
// and whether the word was closed by the stream's last byte.
module boot_byte_packer
  import boot_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 accept,
  input  logic [7:0]           data,
  input  logic                 last,
  output logic [WORD_W-1:0]    word,
  output logic [NUM_LANES-1:0] mask,
  output logic                 word_last,
  output logic                 word_ready
);

  logic [LANE_W-1:0]              lane_cnt;
  logic [NUM_LANES-1:0][7:0]      lanes;

  assign word       = lanes;
  assign word_ready = accept & ((lane_cnt == LANE_W'(NUM_LANES-1)) | last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt  <= '0;
      word_last <= 1'b0;
      lanes     <= '0;
      mask      <= '0;
    end else if (clr) begin
      // Clearing the lanes keeps unreceived bytes of a short word at zero.
      lane_cnt  <= '0;
      word_last <= 1'b0;
      lanes     <= '0;
      mask      <= '0;
    end else if (accept) begin
      lane_cnt  <= lane_cnt + LANE_W'(1);
      word_last <= last;
      for (int g = 0; g < NUM_LANES; g++) begin
        if (lane_cnt == LANE_W'(g)) begin
          lanes[g] <= data;
          mask[g]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/boot_image_loader.sv
// Streams a byte image into IM then DM SRAMs while holding the CPU in reset,
// then releases the CPU a fixed number of cycles after the final write.
module boot_image_loader
  import boot_pkg::*;
#(
  parameter int IM_WORDS    = 16384,
  parameter int DM_WORDS    = 16384,
  parameter int RELEASE_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              im_ceb,
  output logic              im_web,
  output logic [WORD_W-1:0] im_bweb,
  output logic [ADDR_W-1:0] im_a,
  output logic [WORD_W-1:0] im_di,
  output logic              dm_ceb,
  output logic              dm_web,
  output logic [WORD_W-1:0] dm_bweb,
  output logic [ADDR_W-1:0] dm_a,
  output logic [WORD_W-1:0] dm_di,
  output logic              cpu_rst,
  output logic              done,
  output logic [IDX_W-1:0]  word_cnt
);

  localparam int RW = (RELEASE_DLY < 2) ? 1 : $clog2(RELEASE_DLY + 1);
  localparam logic [IDX_W:0]   IM_LIM  = (IDX_W+1)'(IM_WORDS);
  localparam logic [IDX_W:0]   CAP_LIM = (IDX_W+1)'(IM_WORDS + DM_WORDS);
  localparam logic [IDX_W-1:0] DM_OFS  = IDX_W'(IM_WORDS);

  state_e                 state, state_nxt;
  logic [RW-1:0]          rel_cnt;
  logic                   accept, start_ok, to_dm, final_word;
  logic                   word_ready, word_last;
  logic [WORD_W-1:0]      pk_word;
  logic [NUM_LANES-1:0]   pk_mask;
  logic [IDX_W-1:0]       dm_idx;
  sram_req_t              wr_req, im_req, dm_req;

  assign accept     = in_valid & in_ready;
  assign start_ok   = start & ((state == IDLE) | (state == DONE));
  assign to_dm      = {1'b0, word_cnt} >= IM_LIM;
  assign dm_idx     = word_cnt - DM_OFS;
  // Widened compare so a full 2^15-word image still terminates.
  assign final_word = word_last | (({1'b0, word_cnt} + (IDX_W+1)'(1)) == CAP_LIM);

  boot_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == WRITE),
    .accept     (accept),
    .data       (in_data),
    .last       (in_last),
    .word       (pk_word),
    .mask       (pk_mask),
    .word_last  (word_last),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok)            word_cnt <= '0;
      else if (state == WRITE) word_cnt <= word_cnt + IDX_W'(1);
      if (state == WRITE)        rel_cnt <= RW'(RELEASE_DLY);
      else if (state == RELEASE) rel_cnt <= rel_cnt - RW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (word_ready) state_nxt = WRITE;
      WRITE:   state_nxt = final_word ? RELEASE : FILL;
      RELEASE: if (rel_cnt == RW'(1)) state_nxt = DONE;
      DONE:    if (start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    cpu_rst       = 1'b1;
    done          = 1'b0;
    im_req        = SRAM_IDLE;
    dm_req        = SRAM_IDLE;
    wr_req.ceb    = 1'b0;
    wr_req.web    = 1'b0;
    wr_req.bweb   = lanes_to_bweb(pk_mask);
    wr_req.a      = to_dm ? dm_idx[ADDR_W-1:0] : word_cnt[ADDR_W-1:0];
    wr_req.di     = pk_word;
    case (state)
      FILL:  in_ready = 1'b1;
      WRITE: if (to_dm) dm_req = wr_req; else im_req = wr_req;
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign {im_ceb, im_web, im_bweb, im_a, im_di} = im_req;
  assign {dm_ceb, dm_web, dm_bweb, dm_a, dm_di} = dm_req;

endmodule

// File: tb/tb_boot_image_loader.sv
// Directed bench for boot_image_loader: an image-level model checks every
// cycle, and each scenario pins a few hand-computed words and addresses.
module tb_boot_image_loader;

  localparam int IM_WORDS    = 4;
  localparam int DM_WORDS    = 4;
  localparam int RELEASE_DLY = 2;
  localparam int CAP         = IM_WORDS + DM_WORDS;
  localparam logic [79:0] PORT_IDLE = {1'b1, 1'b1, 32'hFFFF_FFFF, 14'd0, 32'd0};

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, im_ceb, im_web, dm_ceb, dm_web, cpu_rst, done;
  logic [31:0] im_bweb, im_di, dm_bweb, dm_di;
  logic [13:0] im_a, dm_a;
  logic [14:0] word_cnt;

  always #5 clk = ~clk;

  boot_image_loader #(.IM_WORDS(IM_WORDS), .DM_WORDS(DM_WORDS), .RELEASE_DLY(RELEASE_DLY)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .im_ceb(im_ceb), .im_web(im_web), .im_bweb(im_bweb), .im_a(im_a), .im_di(im_di),
    .dm_ceb(dm_ceb), .dm_web(dm_web), .dm_bweb(dm_bweb), .dm_a(dm_a), .dm_di(dm_di),
    .cpu_rst(cpu_rst), .done(done), .word_cnt(word_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        imc, dmc, rdy;
    logic [13:0] a;
    logic [31:0] di, bweb;
  } wr_t;
  wr_t wlog[$];

  // Image-level model: bytes accepted so far, words written, release countdown.
  logic [7:0]  cur[$];
  bit          mload, mdone, wr_due, wr_final, exp_ready, mdm;
  int          mcnt, rel_left, mad;
  logic [31:0] wr_di, wr_bweb;

  always @(negedge clk) begin
    if (!rst) begin
      mload = 0; mdone = 0; wr_due = 0; wr_final = 0; mcnt = 0; rel_left = 0;
      cur.delete();
      chk("rst_ctrl", {in_ready, cpu_rst, done, word_cnt}, {1'b0, 1'b1, 1'b0, 15'd0});
      chk("rst_im", {im_ceb, im_web, im_bweb, im_a, im_di}, PORT_IDLE);
      chk("rst_dm", {dm_ceb, dm_web, dm_bweb, dm_a, dm_di}, PORT_IDLE);
    end else begin
      if (rel_left > 0) begin
        rel_left--;
        if (rel_left == 0) mdone = 1;
      end
      chk("word_cnt", word_cnt, mcnt);
      chk("done", done, mdone);
      chk("cpu_rst", cpu_rst, !mdone);
      exp_ready = mload && !wr_due;
      chk("in_ready", in_ready, exp_ready);
      if (im_ceb == 1'b0 || dm_ceb == 1'b0)
        wlog.push_back('{imc: im_ceb, dmc: dm_ceb, rdy: in_ready,
                         a: (im_ceb == 1'b0) ? im_a : dm_a,
                         di: (im_ceb == 1'b0) ? im_di : dm_di,
                         bweb: (im_ceb == 1'b0) ? im_bweb : dm_bweb});
      if (wr_due) begin
        mdm = (mcnt >= IM_WORDS);
        mad = mdm ? mcnt - IM_WORDS : mcnt;
        chk(mdm ? "dm_write" : "im_write",
            mdm ? {dm_ceb, dm_web, dm_bweb, dm_a, dm_di} : {im_ceb, im_web, im_bweb, im_a, im_di},
            {1'b0, 1'b0, wr_bweb, 14'(mad), wr_di});
        chk(mdm ? "im_idle_on_dm_write" : "dm_idle_on_im_write",
            mdm ? {im_ceb, im_web, im_bweb, im_a, im_di} : {dm_ceb, dm_web, dm_bweb, dm_a, dm_di},
            PORT_IDLE);
        mcnt++;
        wr_due = 0;
        if (wr_final) begin
          mload = 0;
          rel_left = RELEASE_DLY + 1;
        end
      end else begin
        chk("im_idle", {im_ceb, im_web, im_bweb, im_a, im_di}, PORT_IDLE);
        chk("dm_idle", {dm_ceb, dm_web, dm_bweb, dm_a, dm_di}, PORT_IDLE);
      end
      if (start && !mload && rel_left == 0) begin
        mload = 1; mdone = 0; mcnt = 0;
        cur.delete();
      end else if (exp_ready && in_valid) begin
        cur.push_back(in_data);
        if (cur.size() == 4 || in_last) begin
          wr_di = '0;
          wr_bweb = '1;
          for (int i = 0; i < cur.size(); i++) begin
            wr_di[8*i +: 8] = cur[i];
            wr_bweb[8*i +: 8] = 8'h00;
          end
          wr_due = 1;
          wr_final = in_last || (mcnt + 1 == CAP);
          cur.delete();
        end
      end
    end
  end

  logic [7:0] tx_q[$];

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offers tx_q in order; rnd inserts idle cycles on in_valid.
  task automatic send(input bit last_end, input bit rnd);
    int i = 0, guard = 0;
    bit hs;
    while (i < tx_q.size() && guard < 300) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = tx_q[i];
      in_last  = last_end && (i == tx_q.size() - 1);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("send_all_bytes_accepted", i, tx_q.size());
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done", done, 1'b1);
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl_lit", {in_ready, cpu_rst, done, word_cnt}, {1'b0, 1'b1, 1'b0, 15'd0});
    chk("reset_im_lit", {im_ceb, im_web, im_bweb}, {2'b11, 32'hFFFF_FFFF});
    rst = 1'b1;

    // basic word
    pulse_start();
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    send(1, 0);
    @(negedge clk);
    chk("basic_im", {im_ceb, im_web, im_a, im_di, im_bweb}, {2'b00, 14'd0, 32'h1234_5678, 32'h0});
    @(negedge clk); chk("basic_rel1", {cpu_rst, done}, 2'b10);
    @(negedge clk); chk("basic_rel2", {cpu_rst, done}, 2'b10);
    @(negedge clk); chk("basic_done", {cpu_rst, done, word_cnt}, {2'b01, 15'd1});

    // partial word, restarted from DONE
    pulse_start();
    tx_q = '{8'hAA, 8'hBB};
    send(1, 0);
    @(negedge clk);
    chk("partial_im", {im_ceb, im_a, im_di, im_bweb}, {1'b0, 14'd0, 32'h0000_BBAA, 32'hFFFF_0000});
    wait_done();
    chk("partial_cnt", word_cnt, 15'd1);

    // IM/DM boundary
    base = wlog.size();
    pulse_start();
    tx_q = {};
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i + 1));
    tx_q.push_back(8'hEF); tx_q.push_back(8'hBE); tx_q.push_back(8'hAD); tx_q.push_back(8'hDE);
    send(1, 0);
    wait_done();
    chk("bound_nwr", wlog.size() - base, 5);
    for (int i = 0; i < 4; i++)
      chk("bound_im_addr", {wlog[base+i].imc, wlog[base+i].dmc, wlog[base+i].a}, {2'b01, 14'(i)});
    chk("bound_im_w1", wlog[base+1].di, 32'h0807_0605);
    chk("bound_dm", {wlog[base+4].imc, wlog[base+4].dmc, wlog[base+4].a, wlog[base+4].di},
        {2'b10, 14'd0, 32'hDEAD_BEEF});

    // backpressure
    base = wlog.size();
    pulse_start();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(1, 1);
    wait_done();
    chk("bp_nwr", wlog.size() - base, 2);
    chk("bp_w0", {wlog[base].rdy, wlog[base].a, wlog[base].di}, {1'b0, 14'd0, 32'h4433_2211});
    chk("bp_w1", {wlog[base+1].rdy, wlog[base+1].a, wlog[base+1].di}, {1'b0, 14'd1, 32'h8877_6655});

    // capacity stop without in_last
    base = wlog.size();
    pulse_start();
    tx_q = {};
    for (int i = 0; i < 4 * CAP; i++) tx_q.push_back(8'(8'hA0 + i));
    send(0, 0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (8) begin
      @(negedge clk);
      chk("cap_stall_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done();
    chk("cap_nwr", wlog.size() - base, CAP);
    for (int i = 0; i < CAP; i++)
      chk("cap_addr", {wlog[base+i].dmc, wlog[base+i].a}, {(i < IM_WORDS), 14'(i % IM_WORDS)});
    chk("cap_end", {done, word_cnt}, {1'b1, 15'd8});

    // reset in the middle of a load, then a clean restart
    pulse_start();
    tx_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send(0, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ctrl", {in_ready, cpu_rst, done, word_cnt}, {1'b0, 1'b1, 1'b0, 15'd0});
    chk("midrst_im", {im_ceb, im_web, im_bweb, im_a, im_di}, PORT_IDLE);
    chk("midrst_dm", {dm_ceb, dm_web, dm_bweb, dm_a, dm_di}, PORT_IDLE);
    @(posedge clk); #3 rst = 1'b1;
    base = wlog.size();
    pulse_start();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send(1, 0);
    wait_done();
    chk("restart_nwr", wlog.size() - base, 1);
    chk("restart_w0", {wlog[base].imc, wlog[base].a, wlog[base].di, wlog[base].bweb},
        {1'b0, 14'd0, 32'h0403_0201, 32'h0});

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
